// File: rtl/env_pkg.sv
// Shared types and code-decoding helpers for the multi-channel ADSR envelope block.
package env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } env_state_t;

    // 0 means "instant"; otherwise 2, 4 or 8 ticks per level step
    function automatic logic [3:0] code_period(input logic [1:0] code);
        return (code == 2'd0) ? 4'd0 : (4'd1 << code);
    endfunction

    function automatic logic [8:0] code_length(input logic [2:0] code);
        return 9'd2 << code;
    endfunction

    // Level lands in the top bits, low bits filled with ones so level 0 is still audible
    function automatic logic [15:0] scale_level(input logic [7:0] level, input int shift);
        return (16'(level) << shift) | ((16'd1 << shift) - 16'd1);
    endfunction

endpackage

// File: rtl/env_channel.sv
// One envelope channel: ADSR/length FSM, step and length counters, output register.
module env_channel
    import env_pkg::*;
#(
    parameter int VOL_W = 3,
    parameter int OUT_W = 4,
    parameter int LEN_W = 16
) (
    input  logic             note_clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [1:0]       attack,
    input  logic [1:0]       decay,
    input  logic [VOL_W-1:0] sustain,
    input  logic [2:0]       length,
    input  logic [OUT_W-1:0] wave_in,
    output logic             enable,
    output logic [VOL_W-1:0] level,
    output logic [OUT_W-1:0] wave
);

    localparam int SH = OUT_W - VOL_W;
    localparam logic [VOL_W-1:0] VMAX    = '1;
    localparam logic [VOL_W-1:0] VMAX_M1 = {{(VOL_W-1){1'b1}}, 1'b0};

    env_state_t       state;
    logic [1:0]       atk_q, dec_q;
    logic [VOL_W-1:0] sus_q;
    logic [2:0]       len_q;
    logic [LEN_W-1:0] lenctr;
    logic [3:0]       stepctr;
    logic [3:0]       atk_p, dec_p;
    logic             len_hit;

    assign atk_p   = code_period(atk_q);
    assign dec_p   = code_period(dec_q);
    assign len_hit = (lenctr + LEN_W'(1)) == LEN_W'(code_length(len_q));
    assign enable  = (state != ST_IDLE);

    always_ff @(posedge note_clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            level   <= '0;
            lenctr  <= '0;
            stepctr <= '0;
            wave    <= '0;
            atk_q   <= '0;
            dec_q   <= '0;
            sus_q   <= '0;
            len_q   <= '0;
        end else begin
            wave <= (wave_in == '0 || state == ST_IDLE) ? '0 : OUT_W'(scale_level(8'(level), SH));
            if (trig) begin
                atk_q   <= attack;
                dec_q   <= decay;
                sus_q   <= sustain;
                len_q   <= length;
                lenctr  <= '0;
                stepctr <= '0;
                level   <= '0;
                state   <= ST_ATTACK;
            end else begin
                case (state)
                    ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
                        lenctr <= lenctr + LEN_W'(1);
                        // length expiry wins over any level step on the same edge
                        if (len_hit) begin
                            state   <= ST_RELEASE;
                            stepctr <= '0;
                        end else if (state == ST_ATTACK) begin
                            if (atk_p == '0) begin
                                level <= VMAX;
                                state <= ST_DECAY;
                            end else if (stepctr == atk_p - 4'd1) begin
                                stepctr <= '0;
                                level   <= level + VOL_W'(1);
                                if (level == VMAX_M1) state <= ST_DECAY;
                            end else begin
                                stepctr <= stepctr + 4'd1;
                            end
                        end else if (state == ST_DECAY) begin
                            if (level == sus_q) begin
                                state <= ST_SUSTAIN;
                            end else if (dec_p == '0) begin
                                level <= sus_q;
                            end else if (stepctr == dec_p - 4'd1) begin
                                stepctr <= '0;
                                level   <= level - VOL_W'(1);
                            end else begin
                                stepctr <= stepctr + 4'd1;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (level == '0) begin
                            state <= ST_IDLE;
                        end else if (dec_p == '0) begin
                            level <= '0;
                        end else if (stepctr == dec_p - 4'd1) begin
                            stepctr <= '0;
                            level   <= level - VOL_W'(1);
                        end else begin
                            stepctr <= stepctr + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/envelope_gen_mc.sv
// Multi-channel ADSR envelope and length controller: NUM_CH independent env_channel slices.
module envelope_gen_mc #(
    parameter int NUM_CH = 4,
    parameter int VOL_W  = 3,
    parameter int OUT_W  = 4,
    parameter int LEN_W  = 16
) (
    input  logic                    note_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [2*NUM_CH-1:0]     attack,
    input  logic [2*NUM_CH-1:0]     decay,
    input  logic [VOL_W*NUM_CH-1:0] sustain,
    input  logic [3*NUM_CH-1:0]     length,
    input  logic [OUT_W*NUM_CH-1:0] wave_in,
    output logic [NUM_CH-1:0]       enable_out,
    output logic [VOL_W*NUM_CH-1:0] env_level,
    output logic [OUT_W*NUM_CH-1:0] wave_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        env_channel #(
            .VOL_W(VOL_W),
            .OUT_W(OUT_W),
            .LEN_W(LEN_W)
        ) u_ch (
            .note_clk(note_clk),
            .rst     (rst),
            .trig    (trig[i]),
            .attack  (attack[2*i +: 2]),
            .decay   (decay[2*i +: 2]),
            .sustain (sustain[VOL_W*i +: VOL_W]),
            .length  (length[3*i +: 3]),
            .wave_in (wave_in[OUT_W*i +: OUT_W]),
            .enable  (enable_out[i]),
            .level   (env_level[VOL_W*i +: VOL_W]),
            .wave    (wave_out[OUT_W*i +: OUT_W])
        );
    end

endmodule

// File: tb/tb_envelope_gen_mc.sv
// Bench for envelope_gen_mc: closed-form envelope model (level as a function of
// ticks since trigger) compared against the DUT every edge.
module tb_envelope_gen_mc;

    localparam int NUM_CH = 4, VOL_W = 3, OUT_W = 4, LEN_W = 16, VMAX = 7;

    logic                    note_clk = 1'b0;
    logic                    rst      = 1'b0;
    logic [NUM_CH-1:0]       trig     = '0;
    logic [2*NUM_CH-1:0]     attack   = '0;
    logic [2*NUM_CH-1:0]     decay    = '0;
    logic [VOL_W*NUM_CH-1:0] sustain  = '0;
    logic [3*NUM_CH-1:0]     length   = '0;
    logic [OUT_W*NUM_CH-1:0] wave_in  = '0;
    logic [NUM_CH-1:0]       enable_out;
    logic [VOL_W*NUM_CH-1:0] env_level;
    logic [OUT_W*NUM_CH-1:0] wave_out;

    envelope_gen_mc #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .note_clk  (note_clk),
        .rst       (rst),
        .trig      (trig),
        .attack    (attack),
        .decay     (decay),
        .sustain   (sustain),
        .length    (length),
        .wave_in   (wave_in),
        .enable_out(enable_out),
        .env_level (env_level),
        .wave_out  (wave_out)
    );

    always #5 note_clk = ~note_clk;

    int tests = 0, fails = 0;

    // model: codes latched at trigger and ticks elapsed since then
    bit m_arm[NUM_CH];
    int m_t[NUM_CH], m_pa[NUM_CH], m_pd[NUM_CH], m_len[NUM_CH], m_sus[NUM_CH];
    int e_lvl[NUM_CH], e_wave[NUM_CH];
    bit e_act[NUM_CH];

    function automatic int period(int code);
        return (code == 0) ? 0 : (1 << code);
    endfunction

    // Level at tick t ignoring note length: ramp up, ramp down, clamp at sustain
    function automatic int nat_lvl(int t, int pa, int pd, int sus);
        int ta, v;
        if (t <= 0) return 0;
        ta = (pa == 0) ? 1 : VMAX * pa;
        if (t < ta) return t / pa;
        if (pd == 0) return (t > ta) ? sus : VMAX;
        v = VMAX - (t - ta) / pd;
        return (v < sus) ? sus : v;
    endfunction

    function automatic int ref_lvl(int c);
        int l, v, r;
        if (!m_arm[c]) return 0;
        l = m_len[c];
        if (m_t[c] < l) return nat_lvl(m_t[c], m_pa[c], m_pd[c], m_sus[c]);
        v = nat_lvl(l - 1, m_pa[c], m_pd[c], m_sus[c]);
        if (m_pd[c] == 0) return (m_t[c] > l) ? 0 : v;
        r = v - (m_t[c] - l) / m_pd[c];
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit ref_act(int c);
        int l, v, z;
        if (!m_arm[c]) return 1'b0;
        l = m_len[c];
        if (m_t[c] < l) return 1'b1;
        v = nat_lvl(l - 1, m_pa[c], m_pd[c], m_sus[c]);
        z = l + ((m_pd[c] == 0) ? ((v > 0) ? 1 : 0) : v * m_pd[c]);
        return m_t[c] <= z;
    endfunction

    function automatic logic [7:0] dut_pack(int c);
        return {enable_out[c], env_level[c*VOL_W +: VOL_W], wave_out[c*OUT_W +: OUT_W]};
    endfunction

    function automatic logic [7:0] exp_pack(int c);
        return {e_act[c], 3'(e_lvl[c]), 4'(e_wave[c])};
    endfunction

    // Advance the model by one edge using the inputs currently driven, then clock the DUT
    task automatic step();
        for (int c = 0; c < NUM_CH; c++) begin
            int wv;
            wv = int'(wave_in[c*OUT_W +: OUT_W]);
            e_wave[c] = (wv != 0 && e_act[c]) ? 2 * e_lvl[c] + 1 : 0;
            if (rst) begin
                m_arm[c]  = 1'b0;
                e_wave[c] = 0;
            end else if (trig[c]) begin
                m_arm[c] = 1'b1;
                m_t[c]   = 0;
                m_pa[c]  = period(int'(attack[2*c +: 2]));
                m_pd[c]  = period(int'(decay[2*c +: 2]));
                m_len[c] = 2 << length[3*c +: 3];
                m_sus[c] = int'(sustain[VOL_W*c +: VOL_W]);
            end else if (m_arm[c]) begin
                m_t[c]++;
            end
            e_lvl[c] = ref_lvl(c);
            e_act[c] = ref_act(c);
        end
        @(posedge note_clk);
        #1;
    endtask

    task automatic set_ch(int c, int a, int d, int s, int l, int w);
        attack[2*c +: 2]          = 2'(a);
        decay[2*c +: 2]           = 2'(d);
        sustain[VOL_W*c +: VOL_W] = 3'(s);
        length[3*c +: 3]          = 3'(l);
        wave_in[OUT_W*c +: OUT_W] = 4'(w);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        trig = '0;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wave_in = '1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int c = 0; c < NUM_CH; c++) begin
            tests++;
            if (dut_pack(c) !== 8'd0) begin
                fails++;
                $display("FAIL reset ch%0d: got en/lvl/wave=%0d/%0d/%0d, want 0/0/0", c,
                         enable_out[c], env_level[c*VOL_W +: VOL_W], wave_out[c*OUT_W +: OUT_W]);
            end
        end
    endtask

    task automatic test_adsr_slow();
        do_reset();
        set_ch(0, 1, 1, 3, 7, 15);
        trig[0] = 1'b1;
        step();
        trig[0] = 1'b0;
        for (int k = 1; k <= 270; k++) begin
            step();
            tests++;
            if (dut_pack(0) !== exp_pack(0)) begin
                fails++;
                $display("FAIL adsr_model k=%0d: got %b want %b", k, dut_pack(0), exp_pack(0));
            end
            if (k == 2 || k == 14 || k == 22 || k == 262) begin
                int want;
                want = (k == 2) ? 1 : (k == 14) ? 7 : (k == 22) ? 3 : 0;
                tests++;
                if (env_level[2:0] !== 3'(want) || enable_out[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL adsr_level k=%0d: got lvl=%0d en=%0d, want lvl=%0d en=1",
                             k, env_level[2:0], enable_out[0], want);
                end
            end
            if (k == 23) begin
                tests++;
                if (wave_out[3:0] !== 4'd7) begin
                    fails++;
                    $display("FAIL adsr_wave k=23: got %0d want 7", wave_out[3:0]);
                end
            end
            if (k == 263) begin
                tests++;
                if (enable_out[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL adsr_idle k=263: got en=%0d want 0", enable_out[0]);
                end
            end
        end
    endtask

    task automatic test_instant();
        do_reset();
        set_ch(1, 0, 0, 5, 0, 9);
        trig[1] = 1'b1;
        step();
        trig[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (dut_pack(1) !== exp_pack(1)) begin
                fails++;
                $display("FAIL instant_model k=%0d: got %b want %b", k, dut_pack(1), exp_pack(1));
            end
            if (k == 1) begin
                tests++;
                if (env_level[5:3] !== 3'd7) begin
                    fails++;
                    $display("FAIL instant_vmax k=1: got %0d want 7", env_level[5:3]);
                end
            end
            if (k == 4) begin
                tests++;
                if (enable_out[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL instant_idle k=4: got en=%0d want 0", enable_out[1]);
                end
            end
        end
    endtask

    task automatic test_len_expiry();
        do_reset();
        set_ch(2, 3, 2, 2, 1, 5);
        trig[2] = 1'b1;
        step();
        trig[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            tests++;
            if (dut_pack(2) !== exp_pack(2)) begin
                fails++;
                $display("FAIL lenexp_model k=%0d: got %b want %b", k, dut_pack(2), exp_pack(2));
            end
            if (k == 4 || k == 5) begin
                tests++;
                if (env_level[8:6] !== 3'd0 || enable_out[2] !== (k == 4)) begin
                    fails++;
                    $display("FAIL lenexp_edge k=%0d: got lvl=%0d en=%0d, want lvl=0 en=%0d",
                             k, env_level[8:6], enable_out[2], (k == 4));
                end
            end
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        set_ch(3, 0, 1, 4, 7, 3);
        trig[3] = 1'b1;
        step();
        trig[3] = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        tests++;
        if (env_level[11:9] !== 3'd4) begin
            fails++;
            $display("FAIL retrig_sustain: got %0d want 4", env_level[11:9]);
        end
        set_ch(3, 2, 0, 6, 2, 3);
        trig[3] = 1'b1;
        step();
        trig[3] = 1'b0;
        tests++;
        if (env_level[11:9] !== 3'd0 || enable_out[3] !== 1'b1) begin
            fails++;
            $display("FAIL retrig_restart: got lvl=%0d en=%0d, want lvl=0 en=1",
                     env_level[11:9], enable_out[3]);
        end
        for (int k = 1; k <= 20; k++) begin
            // codes changing mid-note must be ignored
            if (k == 2) set_ch(3, 1, 3, 1, 0, 3);
            step();
            tests++;
            if (dut_pack(3) !== exp_pack(3)) begin
                fails++;
                $display("FAIL retrig_model k=%0d: got %b want %b", k, dut_pack(3), exp_pack(3));
            end
            if (k == 4) begin
                tests++;
                if (env_level[11:9] !== 3'd1) begin
                    fails++;
                    $display("FAIL retrig_newcode k=4: got %0d want 1", env_level[11:9]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ch(0, 0, 0, 2, 3, 6);
        trig[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if (dut_pack(0) !== exp_pack(0) || env_level[2:0] !== 3'd0) begin
                fails++;
                $display("FAIL b2b_held k=%0d: got %b want %b", k, dut_pack(0), exp_pack(0));
            end
        end
        trig[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            tests++;
            if (dut_pack(0) !== exp_pack(0)) begin
                fails++;
                $display("FAIL b2b_after k=%0d: got %b want %b", k, dut_pack(0), exp_pack(0));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 900; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit fire;
                fire = (k < 12) ? (k == 3 * c) : ($urandom_range(0, 59) == 0);
                trig[c] = fire;
                if (fire || $urandom_range(0, 9) == 0)
                    set_ch(c, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                           $urandom_range(0, 7), 0);
                wave_in[OUT_W*c +: OUT_W] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                tests++;
                if (dut_pack(c) !== exp_pack(c)) begin
                    fails++;
                    $display("FAIL random ch%0d k=%0d: got %b want %b", c, k, dut_pack(c), exp_pack(c));
                end
            end
        end
        trig = '0;
    endtask

    initial begin
        test_reset();
        test_adsr_slow();
        test_instant();
        test_len_expiry();
        test_retrigger();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
